arf_access_sequencer: RTL and testbench
=======================================

// Module: arf_access_sequencer
// PURPOSE
// - Command-driven controller on the driving side of the address register file (ARF): issues FunSel/RSel/OutASel.
// - Consumes the ARF's registered OutA as the memory address for instruction fetch, push, pop and SP init.
// - Sits between the control unit (cmd/rsp handshake) and ARF plus byte memory. Hides ARF RSel bit mapping and output latency.
// PARAMETERS
// - STACK_DEPTH  16  max pushed bytes before overflow (used only with ARF_SEQ_BOUNDS_EN)
// - FETCH_BYTES  2   instruction bytes per FETCH, 1 or 2; ir_out[15:8] = 0 when 1
// PORTS
// - clk          in   1   clock, rising edge
// - rst          in   1   synchronous, active-high reset
// - cmd_valid    in   1   command request
// - cmd_ready    out  1   high only in IDLE; accept = cmd_valid & cmd_ready
// - cmd_op       in   2   00 FETCH, 01 PUSH, 10 POP, 11 SP_INIT
// - cmd_data     in   8   PUSH data / SP_INIT value, latched on accept
// - rsp_valid    out  1   one-cycle pulse on completion
// - rsp_data     out  8   POP result, held until next rsp_valid
// - rsp_err      out  1   valid with rsp_valid; stack over/underflow
// - ir_out       out  16  FETCH result {hi,lo}, held until next FETCH completes
// - arf_funsel   out  2   ARF FunSel: 00 clr, 01 load, 10 inc, 11 dec
// - arf_rsel     out  3   ARF RSel; 000 = no register changes
// - arf_outasel  out  2   ARF OutASel: 00 AR, 01 SP, 10 PC-previous, 11 PC
// - arf_i        out  8   ARF load input (= latched cmd_data)
// - arf_outa     in   8   ARF OutA; registered: value selected at edge N is visible after N, pre-update
// - mem_addr     out  8   memory address (= arf_outa in access states)
// - mem_rd       out  1   sync read; mem_rdata valid the following cycle
// - mem_wr       out  1   write strobe; mem_wdata written at the edge
// - mem_wdata    out  8   write data
// - mem_rdata    in   8   read data
// BEHAVIOUR
// - RSel mapping: load/clear use bit0 PC, bit1 AR, bit2 SP; inc/dec use bit2 PC, bit1 AR, bit0 SP.
// - Reset: state IDLE; rsp_valid, rsp_err, mem_rd, mem_wr = 0; arf_rsel = 000; ir_out, rsp_data = 0; depth = 0.
//   ARF contents untouched.
// - Reset mid-operation aborts the command with no rsp_valid. A write already in its cycle completes.
// - Outputs are decoded from the registered state. In IDLE: arf_rsel = 000, mem_rd = mem_wr = 0.
// - FETCH (2 bytes): F1 outasel=11, inc PC.
//   F2 mem_rd@arf_outa (old PC), outasel=11, inc PC.
//   F3 lo<=mem_rdata, mem_rd@arf_outa.
//   F4 hi<=mem_rdata, rsp_valid, ir_out updated. Latency accept->rsp = 4 clk; PC += 2.
// - FETCH (1 byte): F1, F2 without second inc, F3 captures lo and responds.
// - PUSH (post-decrement): P1 outasel=01, dec SP. P2 mem_wr@arf_outa (old SP), data=cmd_data, rsp_valid.
// - POP (pre-increment): O1 inc SP. O2 outasel=01, rsel=000. O3 mem_rd@arf_outa. O4 rsp_data<=mem_rdata, rsp_valid.
// - SP_INIT: S1 funsel=01, rsel=100, arf_i=cmd_data; depth<=0; rsp_valid in S1.
// - SP and PC wrap modulo 256. Back-to-back commands: next accept is the cycle after rsp_valid.
// CONFIGURATION
// - ARF_SEQ_BOUNDS_EN defined:
//   - depth counter 0..STACK_DEPTH, +1 on PUSH, -1 on POP.
//   - PUSH at depth==STACK_DEPTH and POP at depth==0 skip all ARF/memory activity.
//   - These respond next cycle with rsp_valid=1, rsp_err=1, rsp_data unchanged.
// - ARF_SEQ_BOUNDS_EN undefined: no counter; rsp_err tied 0; pushes and pops always execute and SP wraps.
// TESTING
// - PC=0x10, mem[0x10]=0x3A, mem[0x11]=0xC5, FETCH -> rsp_valid 4 clk after accept, ir_out=0xC53A, PC=0x12.
// - SP_INIT 0xFF; PUSH 0x55; PUSH 0x66 -> mem[0xFF]=0x55, mem[0xFE]=0x66, SP=0xFD.
//   Then POP, POP -> rsp_data 0x66 then 0x55, SP=0xFF.
// - SP_INIT 0x00, PUSH 0x11 -> mem[0x00]=0x11, SP=0xFF (wrap); cmd_ready low throughout, high after rsp.
// - Bounds on, STACK_DEPTH=2: SP_INIT 0x80, three PUSHes -> third rsp_err=1, SP=0x7E, mem[0x7E] unchanged.
//   Bounds on: POP on empty -> rsp_err=1.
// - rst asserted in F2 of a FETCH -> next cycle IDLE, no rsp_valid, ir_out=0, cmd_ready=1, mem_rd=0.
// - cmd_valid held with back-to-back PUSHes -> accepts spaced 3 clk, arf_rsel=000 in every IDLE cycle.

Source files
------------

// File: rtl/arf_access_sequencer.sv
// ARF access sequencer: turns FETCH/PUSH/POP/SP_INIT commands into ARF FunSel/RSel/OutASel and byte-memory strobes.
// Optional stack over/underflow checking is compiled in with `define ARF_SEQ_BOUNDS_EN.
module arf_access_sequencer #(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned FETCH_BYTES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic [15:0] ir_out,
  output logic [1:0]  arf_funsel,
  output logic [2:0]  arf_rsel,
  output logic [1:0]  arf_outasel,
  output logic [7:0]  arf_i,
  input  logic [7:0]  arf_outa,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [1:0] FS_CLR  = 2'b00;
  localparam logic [1:0] FS_LOAD = 2'b01;
  localparam logic [1:0] FS_INC  = 2'b10;
  localparam logic [1:0] FS_DEC  = 2'b11;
  localparam logic [1:0] OA_SP   = 2'b01;
  localparam logic [1:0] OA_PC   = 2'b11;
  // RSel bit meaning differs between load/clear and inc/dec
  localparam logic [2:0] RS_LD_SP = 3'b100;
  localparam logic [2:0] RS_ID_PC = 3'b100;
  localparam logic [2:0] RS_ID_SP = 3'b001;
  localparam bit TWO_BYTE = (FETCH_BYTES == 2);

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_F3, S_F4, S_P1, S_P2,
    S_O1, S_O2, S_O3, S_O4, S_SI, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cmd_q;
  logic [7:0]  lo_q;
  logic [15:0] ir_q;
  logic [7:0]  rdata_q;
  logic        full, empty;
  logic        fetch_done;
  logic [15:0] ir_new;

`ifdef ARF_SEQ_BOUNDS_EN
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  logic [DW-1:0] depth;

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else begin
      case (state)
        S_SI:    depth <= '0;
        S_P2:    depth <= depth + DW'(1);
        S_O4:    depth <= depth - DW'(1);
        default: depth <= depth;
      endcase
    end
  end

  assign full    = (depth == DW'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign rsp_err = (state == S_ERR);
`else
  assign full    = 1'b0;
  assign empty   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    arf_funsel  = FS_CLR;
    arf_rsel    = 3'b000;
    arf_outasel = 2'b00;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            2'b00:   state_nx = S_F1;
            2'b01:   state_nx = full  ? S_ERR : S_P1;
            2'b10:   state_nx = empty ? S_ERR : S_O1;
            default: state_nx = S_SI;
          endcase
        end
      end
      S_F1: begin
        arf_outasel = OA_PC;
        arf_funsel  = FS_INC;
        arf_rsel    = RS_ID_PC;
        state_nx    = S_F2;
      end
      S_F2: begin
        mem_rd      = 1'b1;
        arf_outasel = OA_PC;
        if (TWO_BYTE) begin
          arf_funsel = FS_INC;
          arf_rsel   = RS_ID_PC;
        end
        state_nx = S_F3;
      end
      S_F3: begin
        if (TWO_BYTE) begin
          mem_rd   = 1'b1;
          state_nx = S_F4;
        end else begin
          rsp_valid = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      S_F4: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      S_P1: begin
        arf_outasel = OA_SP;
        arf_funsel  = FS_DEC;
        arf_rsel    = RS_ID_SP;
        state_nx    = S_P2;
      end
      S_P2: begin
        arf_outasel = OA_SP;
        mem_wr      = 1'b1;
        rsp_valid   = 1'b1;
        state_nx    = S_IDLE;
      end
      S_O1: begin
        arf_outasel = OA_SP;
        arf_funsel  = FS_INC;
        arf_rsel    = RS_ID_SP;
        state_nx    = S_O2;
      end
      // OutA is registered pre-update, so the incremented SP is selected one cycle later
      S_O2: begin
        arf_outasel = OA_SP;
        state_nx    = S_O3;
      end
      S_O3: begin
        mem_rd   = 1'b1;
        state_nx = S_O4;
      end
      S_O4: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      S_SI: begin
        arf_funsel = FS_LOAD;
        arf_rsel   = RS_LD_SP;
        rsp_valid  = 1'b1;
        state_nx   = S_IDLE;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign fetch_done = (state == S_F4) || (!TWO_BYTE && (state == S_F3));
  assign ir_new     = TWO_BYTE ? {mem_rdata, lo_q} : {8'h00, mem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= '0;
      lo_q    <= '0;
      ir_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (cmd_valid && cmd_ready) cmd_q <= cmd_data;
      if (state == S_F3) lo_q <= mem_rdata;
      if (fetch_done) ir_q <= ir_new;
      if (state == S_O4) rdata_q <= mem_rdata;
    end
  end

  // Results are forwarded in the response cycle and held in registers afterwards
  assign ir_out    = fetch_done ? ir_new : ir_q;
  assign rsp_data  = (state == S_O4) ? mem_rdata : rdata_q;
  assign arf_i     = cmd_q;
  assign mem_addr  = arf_outa;
  assign mem_wdata = cmd_q;

endmodule

// File: tb/tb_arf_access_sequencer.sv
// Bench for arf_access_sequencer: ARF + byte memory environment, directed table, hand sequences and random commands
// checked against a command-level stack/fetch reference model.
module tb_arf_access_sequencer;

  localparam int unsigned SD = 2;
  localparam int unsigned FB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_data;
  logic [15:0] ir_out;
  logic [1:0]  arf_funsel, arf_outasel;
  logic [2:0]  arf_rsel;
  logic [7:0]  arf_i, arf_outa, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;

  arf_access_sequencer #(.STACK_DEPTH(SD), .FETCH_BYTES(FB)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ir_out(ir_out), .arf_funsel(arf_funsel), .arf_rsel(arf_rsel), .arf_outasel(arf_outasel),
    .arf_i(arf_i), .arf_outa(arf_outa), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ARF and memory environment; backdoor ports preload state
  logic [7:0] pc_m, sp_m, ar_m, outa_m, rdata_m;
  logic [7:0] mem_m [256];
  logic       bd_reg_en = 1'b0, bd_mem_en = 1'b0;
  logic [7:0] bd_pc, bd_sp, bd_addr, bd_data;

  always @(posedge clk) begin
    if (bd_reg_en) begin
      pc_m <= bd_pc; sp_m <= bd_sp; ar_m <= 8'h5A;
    end else begin
      case (arf_funsel)
        2'b00: begin
          if (arf_rsel[0]) pc_m <= 8'h00;
          if (arf_rsel[1]) ar_m <= 8'h00;
          if (arf_rsel[2]) sp_m <= 8'h00;
        end
        2'b01: begin
          if (arf_rsel[0]) pc_m <= arf_i;
          if (arf_rsel[1]) ar_m <= arf_i;
          if (arf_rsel[2]) sp_m <= arf_i;
        end
        2'b10: begin
          if (arf_rsel[2]) pc_m <= pc_m + 8'd1;
          if (arf_rsel[1]) ar_m <= ar_m + 8'd1;
          if (arf_rsel[0]) sp_m <= sp_m + 8'd1;
        end
        default: begin
          if (arf_rsel[2]) pc_m <= pc_m - 8'd1;
          if (arf_rsel[1]) ar_m <= ar_m - 8'd1;
          if (arf_rsel[0]) sp_m <= sp_m - 8'd1;
        end
      endcase
    end
    case (arf_outasel)
      2'b00:   outa_m <= ar_m;
      2'b01:   outa_m <= sp_m;
      default: outa_m <= pc_m;
    endcase
    if (mem_wr) mem_m[mem_addr] <= mem_wdata;
    if (bd_mem_en) mem_m[bd_addr] <= bd_data;
    if (mem_rd) rdata_m <= mem_m[mem_addr];
  end
  assign arf_outa  = outa_m;
  assign mem_rdata = rdata_m;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of each command
  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_pc, ref_sp, ref_rd;
  logic [15:0] ref_ir;
  int          ref_depth;

  task automatic ref_cmd(input logic [1:0] op, input logic [7:0] d, output int lat,
                         output logic [7:0] rd, output logic [15:0] ir, output logic err);
    err = 1'b0;
    case (op)
      2'd0: begin
        if (FB == 2) begin
          ref_ir = {ref_mem[8'(ref_pc + 8'd1)], ref_mem[ref_pc]};
          ref_pc = ref_pc + 8'd2; lat = 4;
        end else begin
          ref_ir = {8'h00, ref_mem[ref_pc]};
          ref_pc = ref_pc + 8'd1; lat = 3;
        end
      end
      2'd1: begin
`ifdef ARF_SEQ_BOUNDS_EN
        if (ref_depth == int'(SD)) begin err = 1'b1; lat = 1; end else
`endif
        begin
          ref_mem[ref_sp] = d; ref_sp = ref_sp - 8'd1; ref_depth++; lat = 2;
        end
      end
      2'd2: begin
`ifdef ARF_SEQ_BOUNDS_EN
        if (ref_depth == 0) begin err = 1'b1; lat = 1; end else
`endif
        begin
          ref_sp = ref_sp + 8'd1; ref_rd = ref_mem[ref_sp]; ref_depth--; lat = 4;
        end
      end
      default: begin
        ref_sp = d; ref_depth = 0; lat = 1;
      end
    endcase
    rd = ref_rd; ir = ref_ir;
  endtask

  task automatic exec(input logic [1:0] op, input logic [7:0] d, input int gap, output int lat,
                      output logic [7:0] rd, output logic [15:0] ir, output logic err);
    bit early;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1'b1);
    chk("rsel_idle", arf_rsel, 3'b000);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 8'($urandom);
    lat = 0; early = 1'b0; rd = '0; ir = '0; err = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (rsp_valid) begin
        lat = c; rd = rsp_data; ir = ir_out; err = rsp_err;
        break;
      end
      if (cmd_ready) early = 1'b1;
      @(negedge clk);
    end
    chk("ready_busy", early, 1'b0);
    @(posedge clk); #1;
    chk("rsp_pulse", rsp_valid, 1'b0);
  endtask

  task automatic check_cmd(input logic [1:0] op, input logic [7:0] d, input int gap);
    int el, al; logic [7:0] erd, ard; logic [15:0] eir, air; logic eerr, aerr;
    ref_cmd(op, d, el, erd, eir, eerr);
    exec(op, d, gap, al, ard, air, aerr);
    chk("latency", al, el);
    chk("rsp_err", aerr, eerr);
    chk("rsp_data", ard, erd);
    chk("ir_out", air, eir);
    chk("pc", pc_m, ref_pc);
    chk("sp", sp_m, ref_sp);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  d;
    int          lat;
    logic [15:0] val;
    logic [7:0]  pc, sp;
    logic        chkm;
    logic [7:0]  ma, mv;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int lat, nmis, acc[2], n, cyc;
    logic [7:0] rd, v, old7e;
    logic [15:0] ir;
    logic err;

    tbl[0] = '{2'd0, 8'h00, 4, 16'hC53A, 8'h12, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{2'd3, 8'hFF, 1, 16'h0000, 8'h12, 8'hFF, 1'b0, 8'h00, 8'h00};
    tbl[2] = '{2'd1, 8'h55, 2, 16'h0000, 8'h12, 8'hFE, 1'b1, 8'hFF, 8'h55};
    tbl[3] = '{2'd1, 8'h66, 2, 16'h0000, 8'h12, 8'hFD, 1'b1, 8'hFE, 8'h66};
    tbl[4] = '{2'd2, 8'h00, 4, 16'h0066, 8'h12, 8'hFE, 1'b0, 8'h00, 8'h00};
    tbl[5] = '{2'd2, 8'h00, 4, 16'h0055, 8'h12, 8'hFF, 1'b0, 8'h00, 8'h00};
    tbl[6] = '{2'd3, 8'h00, 1, 16'h0000, 8'h12, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[7] = '{2'd1, 8'h11, 2, 16'h0000, 8'h12, 8'hFF, 1'b1, 8'h00, 8'h11};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_rsel", arf_rsel, 3'b000);
    chk("rst_ir", ir_out, 16'h0000);
    chk("rst_rsp_data", rsp_data, 8'h00);
    rst = 1'b0;

    // preload environment and reference
    bd_reg_en = 1'b1; bd_pc = 8'h10; bd_sp = 8'h00;
    bd_mem_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = (i == 16) ? 8'h3A : (i == 17) ? 8'hC5 : 8'($urandom);
      ref_mem[i] = v; bd_addr = 8'(i); bd_data = v;
      @(negedge clk);
      bd_reg_en = 1'b0;
    end
    bd_mem_en = 1'b0;
    ref_pc = 8'h10; ref_sp = 8'h00; ref_rd = 8'h00; ref_ir = 16'h0000; ref_depth = 0;

    for (int i = 0; i < 8; i++) begin
      logic [7:0] erd; logic [15:0] eir; logic eerr; int el;
      ref_cmd(tbl[i].op, tbl[i].d, el, erd, eir, eerr);
      exec(tbl[i].op, tbl[i].d, 0, lat, rd, ir, err);
      chk("tbl_latency", lat, tbl[i].lat);
      chk("tbl_err", err, 1'b0);
      if (tbl[i].op == 2'd0) chk("tbl_ir", ir, tbl[i].val);
      if (tbl[i].op == 2'd2) chk("tbl_pop_data", rd, tbl[i].val[7:0]);
      chk("tbl_pc", pc_m, tbl[i].pc);
      chk("tbl_sp", sp_m, tbl[i].sp);
      if (tbl[i].chkm) chk("tbl_mem", mem_m[tbl[i].ma], tbl[i].mv);
    end
    chk("ir_held", ir_out, 16'hC53A);

    // back-to-back pushes with cmd_valid held
    check_cmd(2'd3, 8'h40, 0);
    ref_cmd(2'd1, 8'h77, lat, rd, ir, err);
    ref_cmd(2'd1, 8'h77, lat, rd, ir, err);
    n = 0; cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'h77;
    while (n < 2 && cyc < 20) begin
      if (cmd_ready) begin
        chk("b2b_rsel_idle", arf_rsel, 3'b000);
        acc[n] = cyc; n++;
      end
      @(negedge clk); cyc++;
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 10 && !rsp_valid; c++) @(negedge clk);
    chk("b2b_rsp_seen", rsp_valid, 1'b1);
    chk("b2b_accepts", n, 2);
    chk("b2b_spacing", acc[1] - acc[0], 3);
    @(posedge clk); #1;
    chk("b2b_mem40", mem_m[8'h40], 8'h77);
    chk("b2b_mem3f", mem_m[8'h3F], 8'h77);
    chk("b2b_sp", sp_m, 8'h3E);

    // reset in F2 of a FETCH
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstF2_rsp_valid", rsp_valid, 1'b0);
    chk("rstF2_ir", ir_out, 16'h0000);
    chk("rstF2_ready", cmd_ready, 1'b1);
    chk("rstF2_mem_rd", mem_rd, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstF2_no_rsp", rsp_valid, 1'b0);
    ref_pc = pc_m; ref_ir = 16'h0000; ref_rd = 8'h00; ref_depth = 0;

`ifdef ARF_SEQ_BOUNDS_EN
    old7e = mem_m[8'h7E];
    check_cmd(2'd3, 8'h80, 0);
    check_cmd(2'd1, 8'hA1, 0);
    check_cmd(2'd1, 8'hA2, 0);
    exec(2'd1, 8'hA3, 0, lat, rd, ir, err);
    chk("ovf_err", err, 1'b1);
    chk("ovf_latency", lat, 1);
    chk("ovf_sp", sp_m, 8'h7E);
    chk("ovf_mem7e", mem_m[8'h7E], old7e);
    check_cmd(2'd3, 8'h80, 0);
    exec(2'd2, 8'h00, 0, lat, rd, ir, err);
    chk("udf_err", err, 1'b1);
    chk("udf_sp", sp_m, 8'h80);
`endif

    for (int i = 0; i < 150; i++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 9);
      op = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      check_cmd(op, 8'($urandom), $urandom_range(0, 2));
    end

    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem_m[i] !== ref_mem[i]) nmis++;
    chk("final_mem", nmis, 0);
    chk("final_ar", ar_m, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
